seg_scan_driver: RTL and testbench

Two-digit multiplexed 7-segment display driver, directly downstream of the seconds-style timer. Consumes the timer's ones digit `nums_0`, tens digit `nums_1` and carry flag `cout`, and drives a common-anode two-digit display. Snapshots the digits once per frame so the display never tears, blanks digits during switchover to prevent ghosting, and blinks the display for a fixed number of frames on each carry event.

---
 rtl/seg_scan_driver_if.sv | 32 +++
 rtl/seg_scan_driver.sv | 135 +++++++++++++
 tb/tb_seg_scan_driver.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_driver_if.sv
// Display-side bundle for seg_scan_driver: timer digits and carry in, segment/anode drive out.
interface seg_scan_driver_if;
  logic [3:0] nums_0;
  logic [1:0] nums_1;
  logic       cout;
  logic [6:0] seg_n;
  logic [1:0] an_n;
  logic       frame_tick;
  logic       blinking;

  // Producer side: the timer feeding digits and watching the display status.
  modport master (
    output nums_0,
    output nums_1,
    output cout,
    input  seg_n,
    input  an_n,
    input  frame_tick,
    input  blinking
  );

  // Consumer side: the scan driver itself.
  modport slave (
    input  nums_0,
    input  nums_1,
    input  cout,
    output seg_n,
    output an_n,
    output frame_tick,
    output blinking
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Two-digit multiplexed common-anode 7-segment driver with per-frame snapshot, dead-time
// blanking, leading-zero blanking and a carry-triggered blink window.
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEAD         = 4,
  parameter int unsigned BLINK_FRAMES = 8,
  parameter int unsigned LZB          = 1
) (
  input logic               clk,
  input logic               rstn,
  seg_scan_driver_if.slave  bus_io
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);

  localparam logic [PW-1:0] PLast = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PDead = PW'(DEAD);
  localparam logic [BW-1:0] BLoad = BW'(BLINK_FRAMES);

  localparam logic [6:0] SegBlank = 7'h7F;
  localparam logic [6:0] SegDash  = 7'h3F;

  // Scan and capture state
  logic [PW-1:0] p_q, p_d;
  logic          s_q, s_d;
  logic [3:0]    snap0_q, snap0_d;
  logic [1:0]    snap1_q, snap1_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          cout_q, cout_d;

  // Registered outputs
  logic [6:0] seg_q, seg_d;
  logic [1:0] an_q, an_d;
  logic       frame_tick_q, frame_tick_d;
  logic       blinking_q, blinking_d;

  logic       slot_end;
  logic       frame_end;
  logic       cout_rise;
  logic       dead;
  logic       dark;
  logic       tens_blank;
  logic       blank;
  logic [3:0] digit;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SegDash;
    endcase
    return seg;
  endfunction

  always_comb begin
    slot_end  = (p_q == PLast);
    frame_end = slot_end & s_q;
    cout_rise = bus_io.cout & ~cout_q;

    p_d    = slot_end ? '0 : p_q + PW'(1);
    s_d    = s_q ^ slot_end;
    cout_d = bus_io.cout;

    // Digits are captured only at frame end so a frame never mixes old and new values.
    snap0_d = snap0_q;
    snap1_d = snap1_q;
    if (frame_end) begin
      snap0_d = bus_io.nums_0;
      snap1_d = bus_io.nums_1;
    end

    // A fresh edge restarts the window and swallows a coincident frame-end decrement.
    blink_cnt_d = blink_cnt_q;
    if (cout_rise) begin
      blink_cnt_d = BLoad;
    end else if (frame_end && (blink_cnt_q != '0)) begin
      blink_cnt_d = blink_cnt_q - BW'(1);
    end
  end

  always_comb begin
    dead       = (p_q < PDead);
    dark       = blink_cnt_q[0];
    tens_blank = s_q && (LZB != 0) && (snap1_q == 2'd0);
    blank      = dead | dark | tens_blank;
    digit      = s_q ? {2'b00, snap1_q} : snap0_q;

    seg_d        = blank ? SegBlank : decode(digit);
    an_d         = blank ? 2'b11 : (s_q ? 2'b01 : 2'b10);
    frame_tick_d = frame_end;
    blinking_d   = (blink_cnt_q != '0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p_q          <= '0;
      s_q          <= 1'b0;
      snap0_q      <= 4'd0;
      snap1_q      <= 2'd0;
      blink_cnt_q  <= '0;
      cout_q       <= 1'b0;
      seg_q        <= SegBlank;
      an_q         <= 2'b11;
      frame_tick_q <= 1'b0;
      blinking_q   <= 1'b0;
    end else begin
      p_q          <= p_d;
      s_q          <= s_d;
      snap0_q      <= snap0_d;
      snap1_q      <= snap1_d;
      blink_cnt_q  <= blink_cnt_d;
      cout_q       <= cout_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
      blinking_q   <= blinking_d;
    end
  end

  assign bus_io.seg_n      = seg_q;
  assign bus_io.an_n       = an_q;
  assign bus_io.frame_tick = frame_tick_q;
  assign bus_io.blinking   = blinking_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=8, DEAD=2, BLINK_FRAMES=4 (16-cycle frames).
module tb_seg_scan_driver;

  localparam logic [6:0] DEC [0:10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                        7'h02, 7'h78, 7'h00, 7'h10, 7'h3F};

  logic clk;
  logic rstn;
  int   n_tests;
  int   n_fail;
  int   cyc;

  seg_scan_driver_if bus ();
  seg_scan_driver_if bus_z ();

  assign bus_z.nums_0 = bus.nums_0;
  assign bus_z.nums_1 = bus.nums_1;
  assign bus_z.cout   = bus.cout;

  seg_scan_driver #(
    .SCAN_DIV     (8),
    .DEAD         (2),
    .BLINK_FRAMES (4),
    .LZB          (1)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .bus_io (bus)
  );

  seg_scan_driver #(
    .SCAN_DIV     (8),
    .DEAD         (2),
    .BLINK_FRAMES (4),
    .LZB          (0)
  ) dut_nolzb (
    .clk    (clk),
    .rstn   (rstn),
    .bus_io (bus_z)
  );

  always #5 clk = ~clk;

  // Expected display for frame phase ph (0..15) given the snapshot digits.
  function automatic void exp_out(input int ph, input int d0, input int d1, input bit lzb,
                                  input bit dark, output logic [1:0] an, output logic [6:0] seg);
    int p;
    bit s;
    p = ph % 8;
    s = (ph >= 8);
    if (p < 2 || dark || (s && lzb && d1 == 0)) begin
      an  = 2'b11;
      seg = 7'h7F;
    end else if (!s) begin
      an  = 2'b10;
      seg = DEC[(d0 > 9) ? 10 : d0];
    end else begin
      an  = 2'b01;
      seg = DEC[d1];
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_ph(input int ph);
    do tick(); while (((cyc - 1) % 16) != ph);
  endtask

  task automatic test_reset();
    #2;
    rstn = 1'b0;
    #1;
    n_tests++;
    if (bus.seg_n !== 7'h7F || bus.an_n !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_async seg=%h an=%b expected seg=7f an=11", bus.seg_n, bus.an_n);
    end
    n_tests++;
    if (bus.frame_tick !== 1'b0 || bus.blinking !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags ft=%b blink=%b expected 0 0", bus.frame_tick, bus.blinking);
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (bus.seg_n !== 7'h7F || bus.an_n !== 2'b11 || bus.frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held seg=%h an=%b ft=%b expected 7f 11 0",
               bus.seg_n, bus.an_n, bus.frame_tick);
    end
    rstn = 1'b1;
    cyc  = 0;
  endtask

  task automatic test_idle();
    logic [1:0] ean;
    logic [6:0] eseg;
    int ph;
    for (int i = 0; i < 32; i++) begin
      tick();
      ph = (cyc - 1) % 16;
      exp_out(ph, 0, 0, 1'b1, 1'b0, ean, eseg);
      n_tests++;
      if (bus.an_n !== ean || bus.seg_n !== eseg) begin
        n_fail++;
        $display("FAIL idle_scan cyc=%0d an=%b seg=%h expected an=%b seg=%h",
                 cyc, bus.an_n, bus.seg_n, ean, eseg);
      end
      n_tests++;
      if (bus.frame_tick !== (ph == 15) || bus.blinking !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_tick cyc=%0d ft=%b blink=%b expected ft=%b blink=0",
                 cyc, bus.frame_tick, bus.blinking, (ph == 15));
      end
    end
  endtask

  task automatic test_digits();
    logic [1:0] ean;
    logic [6:0] eseg;
    int ph;
    wait_ph(3);
    bus.nums_0 = 4'd7;
    bus.nums_1 = 2'd2;
    for (int i = 0; i < 28; i++) begin
      tick();
      ph = (cyc - 1) % 16;
      if (i < 12) exp_out(ph, 0, 0, 1'b1, 1'b0, ean, eseg);
      else        exp_out(ph, 7, 2, 1'b1, 1'b0, ean, eseg);
      n_tests++;
      if (bus.an_n !== ean || bus.seg_n !== eseg) begin
        n_fail++;
        $display("FAIL digits_72 i=%0d an=%b seg=%h expected an=%b seg=%h",
                 i, bus.an_n, bus.seg_n, ean, eseg);
      end
      n_tests++;
      if (bus.frame_tick !== (ph == 15)) begin
        n_fail++;
        $display("FAIL digits_tick i=%0d ft=%b expected %b", i, bus.frame_tick, (ph == 15));
      end
    end
  endtask

  // Digits change on the snapshot cycle itself; they must show in the very next frame.
  task automatic test_dash();
    logic [1:0] ean;
    logic [6:0] eseg;
    int ph;
    wait_ph(14);
    bus.nums_0 = 4'd12;
    bus.nums_1 = 2'd0;
    for (int i = 0; i < 17; i++) begin
      tick();
      ph = (cyc - 1) % 16;
      if (i == 0) exp_out(ph, 7, 2, 1'b1, 1'b0, ean, eseg);
      else        exp_out(ph, 12, 0, 1'b1, 1'b0, ean, eseg);
      n_tests++;
      if (bus.an_n !== ean || bus.seg_n !== eseg) begin
        n_fail++;
        $display("FAIL dash_lzb1 i=%0d an=%b seg=%h expected an=%b seg=%h",
                 i, bus.an_n, bus.seg_n, ean, eseg);
      end
      if (i == 0) exp_out(ph, 7, 2, 1'b0, 1'b0, ean, eseg);
      else        exp_out(ph, 12, 0, 1'b0, 1'b0, ean, eseg);
      n_tests++;
      if (bus_z.an_n !== ean || bus_z.seg_n !== eseg) begin
        n_fail++;
        $display("FAIL dash_lzb0 i=%0d an=%b seg=%h expected an=%b seg=%h",
                 i, bus_z.an_n, bus_z.seg_n, ean, eseg);
      end
    end
  endtask

  task automatic test_blink();
    logic [1:0] ean;
    logic [6:0] eseg;
    int ph;
    int fi;
    bit dark;
    bit eblink;
    bus.nums_0 = 4'd5;
    bus.nums_1 = 2'd3;
    wait_ph(4);
    bus.cout = 1'b1;
    for (int k = 0; k < 75; k++) begin
      tick();
      ph     = (cyc - 1) % 16;
      fi     = (k < 11) ? 0 : ((k - 11) / 16 + 1);
      dark   = (fi == 1) || (fi == 3);
      eblink = (k != 0) && (fi <= 3);
      if (fi == 0) exp_out(ph, 12, 0, 1'b1, dark, ean, eseg);
      else         exp_out(ph, 5, 3, 1'b1, dark, ean, eseg);
      n_tests++;
      if (bus.an_n !== ean || bus.seg_n !== eseg) begin
        n_fail++;
        $display("FAIL blink_disp k=%0d an=%b seg=%h expected an=%b seg=%h",
                 k, bus.an_n, bus.seg_n, ean, eseg);
      end
      n_tests++;
      if (bus.blinking !== eblink) begin
        n_fail++;
        $display("FAIL blink_flag k=%0d blinking=%b expected %b", k, bus.blinking, eblink);
      end
    end
  endtask

  task automatic test_retrigger();
    logic [1:0] ean;
    logic [6:0] eseg;
    int ph;
    int fi;
    bit dark;
    bit eblink;
    bus.cout = 1'b0;
    wait_ph(4);
    bus.cout = 1'b1;
    for (int k = 0; k < 123; k++) begin
      tick();
      ph     = (cyc - 1) % 16;
      fi     = (k < 11) ? 0 : ((k - 11) / 16 + 1);
      dark   = (fi == 1) || (fi == 3 && k <= 48) || (fi == 4) || (fi == 6);
      eblink = (k >= 1) && (k <= 106);
      exp_out(ph, 5, 3, 1'b1, dark, ean, eseg);
      n_tests++;
      if (bus.an_n !== ean || bus.seg_n !== eseg) begin
        n_fail++;
        $display("FAIL retrig_disp k=%0d an=%b seg=%h expected an=%b seg=%h",
                 k, bus.an_n, bus.seg_n, ean, eseg);
      end
      n_tests++;
      if (bus.blinking !== eblink) begin
        n_fail++;
        $display("FAIL retrig_flag k=%0d blinking=%b expected %b", k, bus.blinking, eblink);
      end
      if (k == 46) bus.cout = 1'b0;
      if (k == 47) bus.cout = 1'b1;
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] ean;
    logic [6:0] eseg;
    int ph;
    bus.cout = 1'b0;
    tick();
    bus.cout = 1'b1;
    wait_ph(10);
    n_tests++;
    if (bus.blinking !== 1'b1 || bus.an_n !== 2'b01 || bus.seg_n !== 7'h30) begin
      n_fail++;
      $display("FAIL pre_reset blink=%b an=%b seg=%h expected 1 01 30",
               bus.blinking, bus.an_n, bus.seg_n);
    end
    bus.cout = 1'b0;
    rstn = 1'b0;
    #1;
    n_tests++;
    if (bus.seg_n !== 7'h7F || bus.an_n !== 2'b11 || bus.frame_tick !== 1'b0 ||
        bus.blinking !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset seg=%h an=%b ft=%b blink=%b expected 7f 11 0 0",
               bus.seg_n, bus.an_n, bus.frame_tick, bus.blinking);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc  = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      ph = (cyc - 1) % 16;
      if (i < 16) exp_out(ph, 0, 0, 1'b1, 1'b0, ean, eseg);
      else        exp_out(ph, 5, 3, 1'b1, 1'b0, ean, eseg);
      n_tests++;
      if (bus.an_n !== ean || bus.seg_n !== eseg || bus.blinking !== 1'b0) begin
        n_fail++;
        $display("FAIL restart i=%0d an=%b seg=%h blink=%b expected an=%b seg=%h blink=0",
                 i, bus.an_n, bus.seg_n, bus.blinking, ean, eseg);
      end
      n_tests++;
      if (bus.frame_tick !== (ph == 15)) begin
        n_fail++;
        $display("FAIL restart_tick i=%0d ft=%b expected %b", i, bus.frame_tick, (ph == 15));
      end
    end
  endtask

  initial begin
    clk        = 1'b0;
    rstn       = 1'b1;
    n_tests    = 0;
    n_fail     = 0;
    cyc        = 0;
    bus.nums_0 = 4'd0;
    bus.nums_1 = 2'd0;
    bus.cout   = 1'b0;
    test_reset();
    test_idle();
    test_digits();
    test_dash();
    test_blink();
    test_retrigger();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "simulation did not finish");
  end

endmodule
